// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset default and FSM state type for the fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with flush; a pop and a push may share a cycle even when full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && count != '0;
        do_push = push && (count != CW'(DEPTH) || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: next-PC selection, credit-limited imem requests, redirect draining and
// buffering of returned {pc, instr} pairs toward decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t state, state_next;
    logic [CW-1:0] outstanding, outstanding_next, drop_cnt, drop_next, remaining;
    logic [CW-1:0] buf_count, tag_count;
    logic [XLEN-1:0] tag_head;
    logic [2*XLEN-1:0] buf_head;
    logic rsp, accept, buf_push, credit;

    always_comb begin
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp              = imem_rvalid && outstanding != '0;
        credit           = int'(outstanding) + int'(buf_count) < FIFO_DEPTH;
        imem_req         = state == RUN && !redirect_valid && !reset && credit;
        imem_addr        = current_pc;
        accept           = imem_req && imem_gnt;
        next_pc          = reset ? RESET_PC
                         : redirect_valid ? redirect_pc & ~XLEN'(INSTR_BYTES - 1)
                         : accept ? current_pc + XLEN'(INSTR_BYTES)
                         : current_pc;
        buf_push         = rsp && state == RUN && !redirect_valid;
        remaining        = outstanding - CW'(rsp);
        outstanding_next = outstanding + CW'(accept) - CW'(rsp);
        drop_next        = redirect_valid ? remaining
                         : state == DRAIN ? drop_cnt - CW'(rsp)
                         : drop_cnt;
        state_next       = redirect_valid ? (remaining != '0 ? DRAIN : RUN)
                         : state == DRAIN ? (drop_next == '0 ? RUN : DRAIN)
                         : state;
        if_valid         = buf_count != '0;
        if_pc            = buf_head[2*XLEN-1:XLEN];
        if_instr         = buf_head[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) tag_q (
        .clk(clk), .reset(reset), .flush(redirect_valid),
        .push(accept), .push_data(current_pc),
        .pop(buf_push), .head(tag_head), .count(tag_count)
    );

    sync_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) instr_buf (
        .clk(clk), .reset(reset), .flush(redirect_valid),
        .push(buf_push), .push_data({tag_head, imem_rdata}),
        .pop(if_valid && if_ready), .head(buf_head), .count(buf_count)
    );

    rvalid_in_flight: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && outstanding == '0));
    tags_track_outstanding: assert property (@(posedge clk) disable iff (reset)
        state == RUN |-> tag_count == outstanding);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus random traffic checked against a queue-based model
// of in-flight fetches and the decode buffer.
module tb_instr_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset, imem_req, imem_gnt, imem_rvalid, redirect_valid, if_valid, if_ready;
    logic [31:0] current_pc, next_pc, imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .current_pc(current_pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [63:0] dec_buf[$];
    int          n_stale = 0;
    logic [31:0] cur = RPC;
    int          cyc = 0;
    int          lat_max = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit g, input bit rd, input logic [31:0] rp,
                        input bit rdy, input bit rv_ok);
        bit rv, exp_req, acc;
        logic [31:0] exp_next;
        req_t r;
        rv = rv_ok && !rst && inflight.size() > 0 && inflight[0].due <= cyc;
        reset          = rst;
        imem_gnt       = g;
        redirect_valid = rd;
        redirect_pc    = rp;
        if_ready       = rdy;
        current_pc     = cur;
        imem_rvalid    = rv;
        imem_rdata     = rv ? inflight[0].addr ^ KEY : $urandom;
        #1;
        exp_req  = !rst && !rd && n_stale == 0 && inflight.size() + dec_buf.size() < DEPTH;
        acc      = exp_req && g;
        exp_next = rst ? RPC : rd ? rp & ~32'h3 : acc ? cur + 32'd4 : cur;
        chk("imem_req", imem_req, exp_req);
        chk("next_pc", next_pc, exp_next);
        chk("imem_addr", imem_addr, cur);
        if (!rst) begin
            chk("if_valid", if_valid, dec_buf.size() > 0);
            if (dec_buf.size() > 0) begin
                chk("if_pc", if_pc, dec_buf[0][63:32]);
                chk("if_instr", if_instr, dec_buf[0][31:0]);
            end
        end
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            dec_buf.delete();
            n_stale = 0;
        end else begin
            if (dec_buf.size() > 0 && rdy) void'(dec_buf.pop_front());
            if (rv) begin
                r = inflight.pop_front();
                if (n_stale > 0) n_stale--;
                else if (!rd) dec_buf.push_back({r.addr, r.addr ^ KEY});
            end
            if (rd) begin
                dec_buf.delete();
                n_stale = inflight.size();
            end
            if (acc) inflight.push_back('{cur, cyc + int'($urandom_range(1, lat_max))});
        end
        cur = exp_next;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        {reset, imem_gnt, imem_rvalid, redirect_valid, if_ready} = '0;
        {current_pc, imem_rdata, redirect_pc} = '0;
        @(negedge clk);
        // streaming
        repeat (3) step(1, 0, 0, 0, 1, 0);
        repeat (10) step(0, 1, 0, 0, 1, 1);
        // backpressure then release
        step(1, 0, 0, 0, 1, 0);
        repeat (6) step(0, 1, 0, 0, 0, 1);
        chk("bp_hold_pc", next_pc, 32'h8);
        repeat (8) step(0, 1, 0, 0, 1, 1);
        // grant stall at 0x10
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 32'h10, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1, 1);
        repeat (3) step(0, 1, 0, 0, 1, 1);
        // redirect with two in flight
        step(1, 0, 0, 0, 1, 0);
        repeat (2) step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 32'h103, 1, 0);
        repeat (8) step(0, 1, 0, 0, 1, 1);
        // redirect coinciding with a response
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 1, 32'h200, 1, 1);
        repeat (5) step(0, 1, 0, 0, 1, 1);
        // reset while draining
        step(1, 0, 0, 0, 1, 0);
        repeat (2) step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 32'h300, 1, 0);
        step(0, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 1);
        chk("drain_reset_valid", if_valid, 1'b0);
        repeat (4) step(0, 1, 0, 0, 1, 1);
        // address wrap
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 32'hFFFF_FFFC, 1, 1);
        chk("wrap_start", next_pc, 32'hFFFF_FFFC);
        repeat (5) step(0, 1, 0, 0, 1, 1);
        // random traffic with variable latency
        lat_max = 3;
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
